// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants and round-robin pick helper
// for the arbitrated register bank.
package lab_pkg;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;

  // First set bit of mask scanning ptr, ptr+1, ... mod n (n <= 8).
  function automatic pick_t rr_pick(
    input logic [7:0] mask,
    input logic [2:0] ptr,
    input int         n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        j = (int'(ptr) + i) % n;
        if (mask[j[2:0]] && !p.vld) begin
          p.vld = 1'b1;
          p.idx = j[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bundle: write requests, grants,
// read port and status.
interface reg_bank_arbiter_if #(
  parameter int N_REQ = lab_pkg::N_REQ,
  parameter int WIDTH = lab_pkg::WIDTH,
  parameter int AW    = lab_pkg::AW
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*AW-1:0]    wr_addr;
  logic [N_REQ*WIDTH-1:0] wr_data;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [AW-1:0]          rd_addr;
  logic [WIDTH-1:0]       rd_data;
  logic [15:0]            wr_count;

  modport master (
    output req, wr_addr, wr_data, rd_addr,
    input  gnt, busy, rd_data, wr_count
  );

  modport slave (
    input  req, wr_addr, wr_data, rd_addr,
    output gnt, busy, rd_data, wr_count
  );

endinterface

// File: rtl/reg_bank_arbiter_bank.sv
// Bank of enabled D registers: one write port,
// one registered read port, sync clear.
module d_reg_bank #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [2**AW];

  // Read samples the old word on a same-address write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      rd <= '0;
    end else begin
      if (we) mem[wa] <= wd;
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting one write per cycle
// into a shared register bank.
module reg_bank_arbiter
  import lab_pkg::*;
#(
  parameter int N_REQ = lab_pkg::N_REQ,
  parameter int WIDTH = lab_pkg::WIDTH,
  parameter int AW    = lab_pkg::AW
) (
  input  logic clk,
  input  logic rst,
  reg_bank_arbiter_if.slave bus
);

  logic [N_REQ-1:0] gnt;
  logic [2:0]       ptr;
  logic [15:0]      cnt;
  logic             busy;
  logic [7:0]       elig;
  pick_t            pick;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;

  // Holding grant masks the requester for one edge.
  always_comb begin
    elig = '0;
    elig[N_REQ-1:0] = bus.req & ~gnt;
    pick = rr_pick(elig, ptr, N_REQ);
    wa = bus.wr_addr[pick.idx*AW +: AW];
    wd = bus.wr_data[pick.idx*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt  <= '0;
      ptr  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (pick.vld) begin
      gnt  <= N_REQ'(1) << pick.idx;
      ptr  <= (pick.idx == 3'(N_REQ-1)) ?
              3'd0 : pick.idx + 3'd1;
      cnt  <= cnt + 16'd1;
      busy <= 1'b1;
    end else begin
      gnt  <= '0;
      busy <= 1'b0;
    end
  end

  d_reg_bank #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_bank (
    .clk(clk),
    .clr(rst),
    .we (pick.vld),
    .wa (wa),
    .wd (wd),
    .ra (bus.rd_addr),
    .rd (bus.rd_data)
  );

  assign bus.gnt      = gnt;
  assign bus.busy     = busy;
  assign bus.wr_count = cnt;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Randomized and directed bench for reg_bank_arbiter
// against a behavioural model.
module tb_reg_bank_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int A  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.N_REQ(NR), .WIDTH(W), .AW(A)) bus();

  reg_bank_arbiter #(.N_REQ(NR), .WIDTH(W), .AW(A)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0]  mbank [2**A];
  logic [NR-1:0] mgnt;
  int            mptr;
  logic [15:0]   mcnt;
  logic [W-1:0]  mrd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: scan from pointer over req & ~last grant.
  task automatic model();
    int w;
    w = -1;
    if (rst) begin
      for (int i = 0; i < 2**A; i++) mbank[i] = '0;
      mrd  = '0;
      mgnt = '0;
      mptr = 0;
      mcnt = '0;
    end else begin
      mrd = mbank[bus.rd_addr];
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (mptr + k) % NR;
        if (w < 0 && bus.req[j] && !mgnt[j]) w = j;
      end
      if (w >= 0) begin
        mbank[bus.wr_addr[w*A +: A]] = bus.wr_data[w*W +: W];
        mgnt = NR'(1) << w;
        mptr = (w + 1) % NR;
        mcnt = mcnt + 16'd1;
      end else begin
        mgnt = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("gnt", bus.gnt, mgnt);
    chk("busy", bus.busy, |mgnt);
    chk("rd_data", bus.rd_data, mrd);
    chk("wr_count", bus.wr_count, mcnt);
  endtask

  task automatic put(int i, logic [A-1:0] a, logic [W-1:0] d);
    bus.req[i] = 1'b1;
    bus.wr_addr[i*A +: A] = a;
    bus.wr_data[i*W +: W] = d;
  endtask

  task automatic do_reset(int n);
    bus.req = '0;
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  int gi;
  int q[$];

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;

    // reset then idle, read every word
    do_reset(2);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.wr_count, 0);
    for (int a = 0; a < 2**A; a++) begin
      bus.rd_addr = A'(a);
      step();
      chk("rst_rd", bus.rd_data, 0);
    end

    // single requester held three cycles
    put(2, 3'd5, 8'hA5);
    step(); chk("sw_g1", bus.gnt, 4'b0100);
    step(); chk("sw_g2", bus.gnt, 4'b0000);
    step(); chk("sw_g3", bus.gnt, 4'b0100);
    chk("sw_cnt", bus.wr_count, 2);
    bus.req = '0;
    bus.rd_addr = 3'd5;
    step(); chk("sw_rd", bus.rd_data, 8'hA5);

    // round-robin with everyone requesting
    do_reset(1);
    for (int i = 0; i < NR; i++) put(i, A'(i), W'(8'h10 + i));
    for (int c = 0; c < 12; c++) begin
      step();
      gi = -1;
      for (int i = 0; i < NR; i++) if (bus.gnt[i]) gi = i;
      chk("rr_seq", gi, c % NR);
      q.push_back(gi);
      if (q.size() > NR) void'(q.pop_front());
      if (q.size() == NR)
        chk("rr_uniq", (q[0] != q[1] && q[0] != q[2] && q[0] != q[3] &&
                        q[1] != q[2] && q[1] != q[3] && q[2] != q[3]), 1);
    end
    bus.req = '0;

    // same-address collision
    do_reset(1);
    put(0, 3'd3, 8'h11);
    put(1, 3'd3, 8'h22);
    bus.rd_addr = 3'd3;
    step(); chk("col_g0", bus.gnt, 4'b0001);
    bus.req[0] = 1'b0;
    step(); chk("col_g1", bus.gnt, 4'b0010);
    chk("col_rd1", bus.rd_data, 8'h11);
    bus.req = '0;
    step(); chk("col_rd2", bus.rd_data, 8'h22);

    // read and write same address
    put(0, 3'd6, 8'h33);
    step();
    put(0, 3'd6, 8'h44);
    bus.req[0] = 1'b0;
    step();
    bus.req[0] = 1'b1;
    bus.rd_addr = 3'd6;
    step(); chk("rw_old", bus.rd_data, 8'h33);
    bus.req = '0;
    step(); chk("rw_new", bus.rd_data, 8'h44);

    // reset mid-stream with pointer moved off zero
    put(1, 3'd1, 8'h77);
    step();
    bus.req = '0;
    step();
    put(1, 3'd1, 8'h01);
    put(2, 3'd2, 8'h02);
    put(3, 3'd3, 8'h03);
    rst = 1'b1;
    step(); chk("mr_gnt", bus.gnt, 0);
    chk("mr_cnt", bus.wr_count, 0);
    rst = 1'b0;
    step(); chk("mr_first", bus.gnt, 4'b0010);
    bus.req = '0;
    bus.rd_addr = 3'd6;
    step(); chk("mr_clr", bus.rd_data, 0);

    // random traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      bus.req = NR'($urandom);
      bus.wr_addr = (NR*A)'($urandom);
      bus.wr_data = {$urandom, $urandom};
      bus.rd_addr = A'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
